// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg
//  Shared types for the instruction/data memory bus arbiter.
//  Contents:
//    MEM_RUN_W / WAIT_CNT_W  widths of the starvation and timeout counters
//    arb_state_e             bus ownership state (idle, fetch owns, data owns)
//    grant_e                 arbitration decision for the current cycle
//    pick_grant()            priority rule: data first, fetch wins once the
//                            data port has used up its run allowance
package bus_arbiter_pkg;

  // The run counter must reach 15 and the wait counter must reach 255.
  localparam int MEM_RUN_W  = 4;
  localparam int WAIT_CNT_W = 8;

  typedef logic [MEM_RUN_W-1:0]  mem_run_t;
  typedef logic [WAIT_CNT_W-1:0] wait_cnt_t;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'b00,
    ARB_OWN_IF  = 2'b01,
    ARB_OWN_MEM = 2'b10
  } arb_state_e;

  typedef enum logic [1:0] {
    GRANT_NONE = 2'b00,
    GRANT_IF   = 2'b01,
    GRANT_MEM  = 2'b10
  } grant_e;

  // The data port normally wins, but once it has taken its full run of
  // grants while fetch was waiting, fetch gets the next slot.
  function automatic grant_e pick_grant(input logic if_cand,
                                        input logic mem_cand,
                                        input logic run_full);
    grant_e g;
    g = GRANT_NONE;
    if (if_cand && (run_full || !mem_cand)) begin
      g = GRANT_IF;
    end else if (mem_cand) begin
      g = GRANT_MEM;
    end
    return g;
  endfunction

endpackage

// File: rtl/bus_arbiter.sv
// bus_arbiter
//  Shares one external memory bus between the instruction-fetch port and
//  the data (mem stage) port. A granted transaction is held on the bus until
//  bus_ack_i (or a timeout abort), and the result is forwarded
//  combinationally to the owning port.
//  Ports:
//    clk, rst                 clock, asynchronous active-high reset
//    if_req_i/if_addr_i       fetch request and address
//    if_rdata_o/if_ack_o      fetched word and 1-cycle completion pulse
//    mem_req_i/we/sel/addr/wdata  data request (load/store)
//    mem_rdata_o/mem_ack_o    load data and 1-cycle completion pulse
//    bus_req_o/we/sel/addr/wdata  registered bus cycle towards memory
//    bus_rdata_i/bus_ack_i    memory response
//    stallreq_if_o/stallreq_mem_o  stall requests towards the pipeline ctrl
//    bus_err_o                1-cycle pulse when a transfer is aborted
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MAX_MEM_RUN = 4,
  parameter int TIMEOUT     = 15
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic [DATA_W-1:0]   if_rdata_o,
  output logic                if_ack_o,
  input  logic                mem_req_i,
  input  logic                mem_we_i,
  input  logic [DATA_W/8-1:0] mem_sel_i,
  input  logic [ADDR_W-1:0]   mem_addr_i,
  input  logic [DATA_W-1:0]   mem_wdata_i,
  output logic [DATA_W-1:0]   mem_rdata_o,
  output logic                mem_ack_o,
  output logic                bus_req_o,
  output logic                bus_we_o,
  output logic [DATA_W/8-1:0] bus_sel_o,
  output logic [ADDR_W-1:0]   bus_addr_o,
  output logic [DATA_W-1:0]   bus_wdata_o,
  input  logic [DATA_W-1:0]   bus_rdata_i,
  input  logic                bus_ack_i,
  output logic                stallreq_if_o,
  output logic                stallreq_mem_o,
  output logic                bus_err_o
);

  localparam mem_run_t  RUN_LIMIT  = mem_run_t'(MAX_MEM_RUN);
  localparam wait_cnt_t WAIT_LIMIT = wait_cnt_t'(TIMEOUT);

  arb_state_e            r_state;
  arb_state_e            w_state_next;
  grant_e                w_grant;

  logic [ADDR_W-1:0]     r_bus_addr;
  logic                  r_bus_we;
  logic [DATA_W/8-1:0]   r_bus_sel;
  logic [DATA_W-1:0]     r_bus_wdata;
  mem_run_t              r_mem_run;
  wait_cnt_t             r_wait_cnt;

  logic                  w_owned;
  logic                  w_timeout;
  logic                  w_done;
  logic                  w_if_done;
  logic                  w_mem_done;
  logic                  w_arb_en;
  logic                  w_if_cand;
  logic                  w_mem_cand;
  logic                  w_run_full;

  // A transfer ends either on the memory's ack or when the wait limit is
  // reached without one; a real ack in the limit cycle still counts as a
  // normal completion rather than an abort.
  assign w_owned    = (r_state != ARB_IDLE);
  assign w_timeout  = w_owned && !bus_ack_i && (r_wait_cnt == WAIT_LIMIT);
  assign w_done     = w_owned && (bus_ack_i || (r_wait_cnt == WAIT_LIMIT));
  assign w_if_done  = w_done && (r_state == ARB_OWN_IF);
  assign w_mem_done = w_done && (r_state == ARB_OWN_MEM);

  // Arbitration runs when idle and in the completion cycle, so a waiting
  // port is granted back-to-back. The port being acked this cycle still has
  // its request raised for the finished transfer and must not be regranted.
  assign w_arb_en   = !w_owned || w_done;
  assign w_if_cand  = if_req_i && !w_if_done;
  assign w_mem_cand = mem_req_i && !w_mem_done;
  assign w_run_full = (r_mem_run == RUN_LIMIT);
  assign w_grant    = w_arb_en ? pick_grant(w_if_cand, w_mem_cand, w_run_full)
                               : GRANT_NONE;

  // State register: reset abandons any transfer in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ARB_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state: a grant always wins over returning to idle, which is what
  // gives gap-free back-to-back transfers.
  always_comb begin
    w_state_next = r_state;
    case (w_grant)
      GRANT_IF:  w_state_next = ARB_OWN_IF;
      GRANT_MEM: w_state_next = ARB_OWN_MEM;
      default: begin
        if (w_done) begin
          w_state_next = ARB_IDLE;
        end
      end
    endcase
  end

  // Outputs: completion is forwarded in the same cycle as bus_ack_i. On an
  // abort the owner still gets its ack so the pipeline unstalls, but with
  // zero data because the bus returned nothing.
  always_comb begin
    if_ack_o    = w_if_done;
    mem_ack_o   = w_mem_done;
    if_rdata_o  = '0;
    mem_rdata_o = '0;
    bus_err_o   = w_timeout;
    if (w_if_done && bus_ack_i) begin
      if_rdata_o = bus_rdata_i;
    end
    if (w_mem_done && bus_ack_i) begin
      mem_rdata_o = bus_rdata_i;
    end
    stallreq_if_o  = if_req_i && !w_if_done;
    stallreq_mem_o = mem_req_i && !w_mem_done;
  end

  // Bus request/address/data registers: captured only at grant so the bus
  // stays stable for the whole transfer even if the port inputs move.
  // Fetches are always full-word reads.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bus_addr  <= '0;
      r_bus_we    <= 1'b0;
      r_bus_sel   <= '0;
      r_bus_wdata <= '0;
    end else begin
      case (w_grant)
        GRANT_IF: begin
          r_bus_addr  <= if_addr_i;
          r_bus_we    <= 1'b0;
          r_bus_sel   <= '1;
          r_bus_wdata <= '0;
        end
        GRANT_MEM: begin
          r_bus_addr  <= mem_addr_i;
          r_bus_we    <= mem_we_i;
          r_bus_sel   <= mem_sel_i;
          r_bus_wdata <= mem_wdata_i;
        end
        default: begin
          if (w_done) begin
            r_bus_addr  <= '0;
            r_bus_we    <= 1'b0;
            r_bus_sel   <= '0;
            r_bus_wdata <= '0;
          end
        end
      endcase
    end
  end

  // Wait counter: counts owned cycles without an ack; restarts on every
  // grant and after every completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wait_cnt <= '0;
    end else if ((w_grant != GRANT_NONE) || w_done) begin
      r_wait_cnt <= '0;
    end else if (w_owned) begin
      r_wait_cnt <= r_wait_cnt + wait_cnt_t'(1);
    end
  end

  // Data-run counter: number of data grants handed out while fetch was
  // waiting. Cleared as soon as fetch is served or stops asking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem_run <= '0;
    end else if (!if_req_i || (w_grant == GRANT_IF)) begin
      r_mem_run <= '0;
    end else if ((w_grant == GRANT_MEM) && !w_run_full) begin
      r_mem_run <= r_mem_run + mem_run_t'(1);
    end
  end

  assign bus_req_o   = w_owned;
  assign bus_we_o    = r_bus_we;
  assign bus_sel_o   = r_bus_sel;
  assign bus_addr_o  = r_bus_addr;
  assign bus_wdata_o = r_bus_wdata;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter
//  Scenario tasks for the fetch/data bus arbiter followed by a randomized
//  traffic run checked against a transaction-level reference model.
module tb_bus_arbiter;

  localparam int ADDR_W      = 32;
  localparam int DATA_W      = 32;
  localparam int MAX_MEM_RUN = 4;
  localparam int TIMEOUT     = 15;

  logic                clk;
  logic                rst;
  logic                if_req_i;
  logic [ADDR_W-1:0]   if_addr_i;
  logic [DATA_W-1:0]   if_rdata_o;
  logic                if_ack_o;
  logic                mem_req_i;
  logic                mem_we_i;
  logic [DATA_W/8-1:0] mem_sel_i;
  logic [ADDR_W-1:0]   mem_addr_i;
  logic [DATA_W-1:0]   mem_wdata_i;
  logic [DATA_W-1:0]   mem_rdata_o;
  logic                mem_ack_o;
  logic                bus_req_o;
  logic                bus_we_o;
  logic [DATA_W/8-1:0] bus_sel_o;
  logic [ADDR_W-1:0]   bus_addr_o;
  logic [DATA_W-1:0]   bus_wdata_o;
  logic [DATA_W-1:0]   bus_rdata_i;
  logic                bus_ack_i;
  logic                stallreq_if_o;
  logic                stallreq_mem_o;
  logic                bus_err_o;

  int compared;
  int mismatched;

  bus_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_MEM_RUN(MAX_MEM_RUN), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ack_o(if_ack_o),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_sel_i(mem_sel_i),
    .mem_addr_i(mem_addr_i), .mem_wdata_i(mem_wdata_i),
    .mem_rdata_o(mem_rdata_o), .mem_ack_o(mem_ack_o),
    .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_sel_o(bus_sel_o),
    .bus_addr_o(bus_addr_o), .bus_wdata_o(bus_wdata_o),
    .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i),
    .stallreq_if_o(stallreq_if_o), .stallreq_mem_o(stallreq_mem_o), .bus_err_o(bus_err_o)
  );

  // Free-running clock, posedge at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Safety net so the run can never hang.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Inputs change 1 time unit after the rising edge; outputs are checked on
  // the falling edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    if_req_i = 0; if_addr_i = '0;
    mem_req_i = 0; mem_we_i = 0; mem_sel_i = '0; mem_addr_i = '0; mem_wdata_i = '0;
    bus_rdata_i = '0; bus_ack_i = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    compared++;
    if ({bus_req_o, if_ack_o, mem_ack_o, bus_err_o, stallreq_if_o, stallreq_mem_o} !== 6'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_outputs: got req/ifack/memack/err/stalls=%b required 000000",
               {bus_req_o, if_ack_o, mem_ack_o, bus_err_o, stallreq_if_o, stallreq_mem_o});
    end
    next_cycle();
    rst = 1'b0;
    mem_req_i = 1; mem_we_i = 0; mem_sel_i = 4'hF; mem_addr_i = 32'h0000_0100;
    next_cycle();
    @(negedge clk);
    compared++;
    if (bus_req_o !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL reset_pre_own_mem: got bus_req_o=%b required 1", bus_req_o);
    end
    #2;
    bus_ack_i = 1'b1;
    rst = 1'b1;
    #1;
    compared++;
    if ({bus_req_o, mem_ack_o, if_ack_o, bus_err_o} !== 4'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_async_abort: got req/memack/ifack/err=%b required 0000",
               {bus_req_o, mem_ack_o, if_ack_o, bus_err_o});
    end
    next_cycle();
    rst = 1'b0;
    mem_req_i = 0; bus_ack_i = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      compared++;
      if ({bus_req_o, mem_ack_o, bus_err_o} !== 3'b0) begin
        mismatched++;
        $display("[TB] FAIL reset_idle_after: got req/memack/err=%b required 000",
                 {bus_req_o, mem_ack_o, bus_err_o});
      end
      next_cycle();
    end
  endtask

  task automatic test_if_only();
    if_req_i = 1; if_addr_i = 32'h0000_0010;
    @(negedge clk);
    compared++;
    if (stallreq_if_o !== 1'b1 || bus_req_o !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL if_request_cycle: got stall=%b req=%b required 1 0", stallreq_if_o, bus_req_o);
    end
    next_cycle();
    @(negedge clk);
    compared++;
    if (bus_req_o !== 1'b1 || bus_addr_o !== 32'h10 || bus_we_o !== 1'b0 || bus_sel_o !== 4'hF) begin
      mismatched++;
      $display("[TB] FAIL if_bus_cycle: got req=%b addr=%h we=%b sel=%h required 1 00000010 0 f",
               bus_req_o, bus_addr_o, bus_we_o, bus_sel_o);
    end
    for (int k = 0; k < 2; k++) begin
      compared++;
      if (if_ack_o !== 1'b0 || stallreq_if_o !== 1'b1) begin
        mismatched++;
        $display("[TB] FAIL if_waiting: got ack=%b stall=%b required 0 1", if_ack_o, stallreq_if_o);
      end
      if (k == 0) begin
        next_cycle();
        @(negedge clk);
      end
    end
    next_cycle();
    bus_ack_i = 1; bus_rdata_i = 32'h3402_0001;
    @(negedge clk);
    compared++;
    if (if_ack_o !== 1'b1 || if_rdata_o !== 32'h3402_0001 || stallreq_if_o !== 1'b0 || mem_ack_o !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL if_ack: got ack=%b rdata=%h stall=%b memack=%b required 1 34020001 0 0",
               if_ack_o, if_rdata_o, stallreq_if_o, mem_ack_o);
    end
    next_cycle();
    if_req_i = 0; bus_ack_i = 0; bus_rdata_i = '0;
    @(negedge clk);
    compared++;
    if (bus_req_o !== 1'b0 || if_ack_o !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL if_release: got req=%b ack=%b required 0 0", bus_req_o, if_ack_o);
    end
    next_cycle();
  endtask

  task automatic test_both_same_cycle();
    if_req_i = 1; if_addr_i = 32'h0000_0020;
    mem_req_i = 1; mem_we_i = 1; mem_sel_i = 4'b1111;
    mem_addr_i = 32'h8000_0004; mem_wdata_i = 32'hDEAD_BEEF;
    next_cycle();
    bus_ack_i = 1; bus_rdata_i = 32'h1111_2222;
    @(negedge clk);
    compared++;
    if (bus_we_o !== 1'b1 || bus_addr_o !== 32'h8000_0004 || bus_wdata_o !== 32'hDEAD_BEEF ||
        bus_sel_o !== 4'hF || mem_ack_o !== 1'b1 || if_ack_o !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL both_mem_first: got we=%b addr=%h wdata=%h sel=%h memack=%b ifack=%b required 1 80000004 deadbeef f 1 0",
               bus_we_o, bus_addr_o, bus_wdata_o, bus_sel_o, mem_ack_o, if_ack_o);
    end
    next_cycle();
    mem_req_i = 0; bus_rdata_i = 32'h5555_0000;
    @(negedge clk);
    compared++;
    if (bus_req_o !== 1'b1 || bus_addr_o !== 32'h20 || bus_we_o !== 1'b0 || if_ack_o !== 1'b1 ||
        if_rdata_o !== 32'h5555_0000 || mem_ack_o !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL both_if_no_gap: got req=%b addr=%h we=%b ifack=%b rdata=%h memack=%b required 1 00000020 0 1 55550000 0",
               bus_req_o, bus_addr_o, bus_we_o, if_ack_o, if_rdata_o, mem_ack_o);
    end
    next_cycle();
    if_req_i = 0; bus_ack_i = 0; bus_rdata_i = '0;
    @(negedge clk);
    compared++;
    if (bus_req_o !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL both_release: got req=%b required 0", bus_req_o);
    end
    next_cycle();
  endtask

  task automatic test_mem_run_limit();
    int memBeforeIf;
    bit ifSeen;
    bit memAfterIf;
    memBeforeIf = 0; ifSeen = 0; memAfterIf = 0;
    if_req_i = 1; if_addr_i = 32'h0000_0080;
    mem_req_i = 1; mem_we_i = 0; mem_sel_i = 4'hF; mem_addr_i = 32'h0000_1000;
    bus_ack_i = 1; bus_rdata_i = 32'h0000_0777;
    for (int cyc = 0; cyc < 30 && !memAfterIf; cyc++) begin
      @(negedge clk);
      if (mem_ack_o === 1'b1) begin
        if (ifSeen) memAfterIf = 1;
        else memBeforeIf++;
      end
      if (if_ack_o === 1'b1) ifSeen = 1;
      next_cycle();
      if (ifSeen) if_req_i = 0;
      mem_addr_i = mem_addr_i + 32'h4;
    end
    mem_req_i = 0; if_req_i = 0; bus_ack_i = 0; bus_rdata_i = '0;
    compared++;
    if (!ifSeen || memBeforeIf < 1 || memBeforeIf > MAX_MEM_RUN) begin
      mismatched++;
      $display("[TB] FAIL mem_run_fetch_served: got ifSeen=%0d dataGrantsBefore=%0d required 1 and 1..%0d",
               ifSeen, memBeforeIf, MAX_MEM_RUN);
    end
    compared++;
    if (!memAfterIf) begin
      mismatched++;
      $display("[TB] FAIL mem_run_data_resumes: got %0d required 1", memAfterIf);
    end
    repeat (3) next_cycle();
  endtask

  task automatic test_timeout();
    mem_req_i = 1; mem_we_i = 0; mem_sel_i = 4'h3; mem_addr_i = 32'h0000_0040;
    bus_ack_i = 0; bus_rdata_i = 32'hFFFF_FFFF;
    next_cycle();
    for (int k = 0; k <= TIMEOUT; k++) begin
      @(negedge clk);
      compared++;
      if (k < TIMEOUT) begin
        if (bus_err_o !== 1'b0 || mem_ack_o !== 1'b0 || bus_req_o !== 1'b1) begin
          mismatched++;
          $display("[TB] FAIL timeout_wait_%0d: got err=%b ack=%b req=%b required 0 0 1",
                   k, bus_err_o, mem_ack_o, bus_req_o);
        end
        next_cycle();
      end else begin
        if (bus_err_o !== 1'b1 || mem_ack_o !== 1'b1 || mem_rdata_o !== 32'h0) begin
          mismatched++;
          $display("[TB] FAIL timeout_abort: got err=%b ack=%b rdata=%h required 1 1 00000000",
                   bus_err_o, mem_ack_o, mem_rdata_o);
        end
      end
    end
    next_cycle();
    mem_req_i = 0; bus_rdata_i = '0;
    @(negedge clk);
    compared++;
    if (bus_req_o !== 1'b0 || bus_err_o !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL timeout_idle: got req=%b err=%b required 0 0", bus_req_o, bus_err_o);
    end
    next_cycle();
    mem_req_i = 1; mem_addr_i = 32'h0000_0044;
    next_cycle();
    bus_ack_i = 1; bus_rdata_i = 32'hCAFE_F00D;
    @(negedge clk);
    compared++;
    if (mem_ack_o !== 1'b1 || mem_rdata_o !== 32'hCAFE_F00D || bus_err_o !== 1'b0 || bus_addr_o !== 32'h44) begin
      mismatched++;
      $display("[TB] FAIL timeout_recover: got ack=%b rdata=%h err=%b addr=%h required 1 cafef00d 0 00000044",
               mem_ack_o, mem_rdata_o, bus_err_o, bus_addr_o);
    end
    next_cycle();
    mem_req_i = 0; bus_ack_i = 0; bus_rdata_i = '0;
    next_cycle();
  endtask

  task automatic test_addr_hold();
    mem_req_i = 1; mem_we_i = 1; mem_sel_i = 4'b0101;
    mem_addr_i = 32'h1234_5678; mem_wdata_i = 32'h0BAD_F00D;
    next_cycle();
    for (int k = 0; k < 3; k++) begin
      mem_addr_i = $urandom(); mem_wdata_i = $urandom(); mem_sel_i = 4'($urandom_range(0, 15));
      @(negedge clk);
      compared++;
      if (bus_addr_o !== 32'h1234_5678 || bus_wdata_o !== 32'h0BAD_F00D || bus_sel_o !== 4'b0101) begin
        mismatched++;
        $display("[TB] FAIL addr_hold_%0d: got addr=%h wdata=%h sel=%h required 12345678 0badf00d 5",
                 k, bus_addr_o, bus_wdata_o, bus_sel_o);
      end
      next_cycle();
    end
    bus_ack_i = 1; mem_addr_i = 32'h0000_0000;
    @(negedge clk);
    compared++;
    if (mem_ack_o !== 1'b1 || bus_addr_o !== 32'h1234_5678) begin
      mismatched++;
      $display("[TB] FAIL addr_hold_ack: got ack=%b addr=%h required 1 12345678", mem_ack_o, bus_addr_o);
    end
    next_cycle();
    mem_req_i = 0; bus_ack_i = 0;
    next_cycle();
  endtask

  // Randomized traffic. The model keeps the transaction currently on the
  // bus (owner and captured request), how long it has waited, and how many
  // data transfers fetch has sat through.
  task automatic test_random_traffic();
    int owner;
    int waited;
    int dataRun;
    int nextOwner;
    logic [31:0] tAddr, tWdata;
    logic [3:0] tSel;
    logic tWe;
    bit ifAckPrev, memAckPrev;
    bit expDone, expErr, expIfAck, expMemAck, ifWants, memWants;
    logic [31:0] expRdata;
    owner = 0; waited = 0; dataRun = 0;
    tAddr = '0; tWdata = '0; tSel = '0; tWe = 0;
    ifAckPrev = 0; memAckPrev = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      next_cycle();
      if (ifAckPrev) if_req_i = 0;
      if (memAckPrev) mem_req_i = 0;
      if (!if_req_i && $urandom_range(0, 1) == 1) begin
        if_req_i = 1; if_addr_i = $urandom() & 32'hFFFF_FFFC;
      end
      if (!mem_req_i && $urandom_range(0, 1) == 1) begin
        mem_req_i = 1; mem_we_i = 1'($urandom_range(0, 1));
        mem_sel_i = 4'($urandom_range(1, 15));
        mem_addr_i = $urandom(); mem_wdata_i = $urandom();
      end
      bus_ack_i = ($urandom_range(0, 2) == 0);
      bus_rdata_i = $urandom();
      @(negedge clk);

      expDone   = (owner != 0) && (bus_ack_i || waited == TIMEOUT);
      expErr    = (owner != 0) && !bus_ack_i && waited == TIMEOUT;
      expIfAck  = expDone && owner == 1;
      expMemAck = expDone && owner == 2;
      expRdata  = bus_ack_i ? bus_rdata_i : 32'h0;

      compared++;
      if (bus_req_o !== (owner != 0) || if_ack_o !== expIfAck || mem_ack_o !== expMemAck || bus_err_o !== expErr) begin
        mismatched++;
        $display("[TB] FAIL rand_ctrl cyc %0d: got req/ifack/memack/err=%b%b%b%b required %b%b%b%b",
                 cyc, bus_req_o, if_ack_o, mem_ack_o, bus_err_o, owner != 0, expIfAck, expMemAck, expErr);
      end
      if (owner != 0) begin
        compared++;
        if (bus_addr_o !== tAddr || bus_we_o !== tWe || bus_sel_o !== tSel || bus_wdata_o !== tWdata) begin
          mismatched++;
          $display("[TB] FAIL rand_bus cyc %0d: got addr=%h we=%b sel=%h wdata=%h required %h %b %h %h",
                   cyc, bus_addr_o, bus_we_o, bus_sel_o, bus_wdata_o, tAddr, tWe, tSel, tWdata);
        end
      end
      if (expIfAck) begin
        compared++;
        if (if_rdata_o !== expRdata) begin
          mismatched++;
          $display("[TB] FAIL rand_if_rdata cyc %0d: got %h required %h", cyc, if_rdata_o, expRdata);
        end
      end
      if (expMemAck) begin
        compared++;
        if (mem_rdata_o !== expRdata) begin
          mismatched++;
          $display("[TB] FAIL rand_mem_rdata cyc %0d: got %h required %h", cyc, mem_rdata_o, expRdata);
        end
      end

      ifAckPrev = expIfAck; memAckPrev = expMemAck;

      nextOwner = 0;
      if (owner == 0 || expDone) begin
        ifWants  = if_req_i && !expIfAck;
        memWants = mem_req_i && !expMemAck;
        if (ifWants && (dataRun == MAX_MEM_RUN || !memWants)) nextOwner = 1;
        else if (memWants) nextOwner = 2;
      end
      if (!if_req_i || nextOwner == 1) dataRun = 0;
      else if (nextOwner == 2 && dataRun < MAX_MEM_RUN) dataRun++;
      if (nextOwner == 1) begin
        tAddr = if_addr_i; tWe = 0; tSel = 4'hF; tWdata = '0;
      end else if (nextOwner == 2) begin
        tAddr = mem_addr_i; tWe = mem_we_i; tSel = mem_sel_i; tWdata = mem_wdata_i;
      end
      if (nextOwner != 0) begin
        owner = nextOwner; waited = 0;
      end else if (expDone) begin
        owner = 0; waited = 0;
      end else if (owner != 0) begin
        waited++;
      end
    end
    next_cycle();
    if_req_i = 0; mem_req_i = 0; bus_ack_i = 1;
    repeat (3) next_cycle();
    bus_ack_i = 0;
  endtask

  initial begin
    compared = 0;
    mismatched = 0;
    test_reset();
    test_if_only();
    test_both_same_cycle();
    test_mem_run_limit();
    test_timeout();
    test_addr_hold();
    test_random_traffic();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
